// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the signals between the load/store unit and its neighbours:
//   the core request/response handshake and the word-organised data memory port.
//
//   Core request : req_valid, req_ready, req_we, req_funct3, req_addr, req_wdata
//   Core response: resp_valid, resp_rdata, resp_err
//   Memory port  : mem_addr, mem_r_enable, mem_w_enable, mem_wdata, mem_rdata
//
//   modport slave  - the load/store unit itself
//   modport master - the environment (core plus data memory)
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_r_enable, mem_w_enable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Turns RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word
//   accesses on a memory with one-cycle registered read and word-only write.
//   Sub-word stores are performed as read-modify-write. Misaligned requests
//   and illegal funct3 codes are answered with resp_err without any memory
//   access.
//
//   Ports:
//     clk  - clock, all state changes on the rising edge
//     rst  - asynchronous active-high reset
//     bus  - load_store_unit_if.slave (request, response and memory port)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RD_DATA,
    WRITE,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;

  // Request captured at the handshake edge; later input changes are ignored.
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  // Store word: req_wdata for SW, replaced by the merged word for SB/SH.
  logic [31:0]       wdata_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              req_bad;
  logic [4:0]        shamt;
  logic [31:0]       lane;
  logic [31:0]       mask;
  logic [31:0]       load_data;
  logic [31:0]       merge_data;

  assign accept = bus.req_valid & bus.req_ready;

  // Legality of the incoming request: funct3 class plus natural alignment.
  // NOTE: every signal driven from always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    req_bad = 1'b1;
    case (bus.req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = bus.req_addr[0];
      3'b010:  req_bad = |bus.req_addr[1:0];
      3'b100:  req_bad = bus.req_we;
      3'b101:  req_bad = bus.req_we | bus.req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)
            state_next = RESP;
          else if (bus.req_we && bus.req_funct3 == 3'b010)
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = RD_DATA;
      RD_DATA: state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift the addressed lane down to bit 0. Legal halfword/word accesses are
  // aligned, so the same shift serves all sizes (zero for LW).
  assign shamt = {addr_q[1:0], 3'b000};
  assign lane  = bus.mem_rdata >> shamt;

  always_comb begin
    load_data = lane;
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  // Read-modify-write merge: funct3_q[0] distinguishes SH from SB.
  assign mask       = funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign merge_data = (bus.mem_rdata & ~(mask << shamt)) | ((wdata_q & mask) << shamt);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values present before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // NOTE: the request and response registers are cleared by reset as well,
  // because mem_addr and resp_rdata must read 0 while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        if (req_bad) begin
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b1;
        end
      end
      if (state == RD_DATA) begin
        if (we_q) begin
          wdata_q <= merge_data;
        end else begin
          resp_rdata_q <= load_data;
          resp_err_q   <= 1'b0;
        end
      end
      if (state == WRITE) begin
        resp_rdata_q <= 32'h0;
        resp_err_q   <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = (state == IDLE) & ~rst;
  assign bus.resp_valid   = (state == RESP);
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.resp_err     = resp_err_q;
  assign bus.mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_r_enable = (state == READ);
  assign bus.mem_w_enable = (state == WRITE);
  assign bus.mem_wdata    = (state == WRITE) ? wdata_q : 32'h0;

endmodule
